// File: rtl/sdram_port_arbiter.sv
// Two-port SDRAM burst arbiter: display reads are favoured, fill writes get starvation protection.
// Latency: grant is combinational in IDLE; command is valid the next cycle; done is passed through in the same cycle.
// Backpressure: cmd_valid_o is held with a stable address until cmd_ready_i; only one burst is ever outstanding.
//
// Ports:
//   clk_i, rst_ni             - clock, asynchronous active-low reset
//   rd_req_i/rd_addr_i        - read burst request (level) and address; rd_gnt_o/rd_done_o pulses back
//   wr_req_i/wr_addr_i        - write burst request (level) and address; wr_gnt_o/wr_done_o pulses back
//   cmd_valid_o/cmd_ready_i   - handshake to SDRAM driver, carrying cmd_we_o and cmd_addr_o
//   cmd_done_i                - driver pulse: current burst finished
//   busy_o                    - arbiter has a burst in progress (not IDLE)
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH   = 24,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_gnt_o,
    output logic                  rd_done_o,
    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    output logic                  wr_gnt_o,
    output logic                  wr_done_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic                  cmd_we_o,
    output logic [ADDR_WIDTH-1:0] cmd_addr_o,
    input  logic                  cmd_done_i,
    output logic                  busy_o
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         starve_q, starve_d;
    // we_q doubles as the latched owner: 1 = write port, 0 = read port.
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_wins;

    // Reads are preferred; a waiting write wins once it has been passed over STARVE_LIMIT times.
    assign wr_wins = wr_req_i && (!rd_req_i || (starve_q == LIMIT));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        we_d        = we_q;
        addr_d      = addr_q;
        rd_gnt_o    = 1'b0;
        wr_gnt_o    = 1'b0;
        rd_done_o   = 1'b0;
        wr_done_o   = 1'b0;
        cmd_valid_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Grant is combinational, so it is also qualified by reset to keep it low while rst_ni is 0.
                if (rst_ni && (rd_req_i || wr_req_i)) begin
                    state_d = S_ISSUE;
                    if (wr_wins) begin
                        wr_gnt_o = 1'b1;
                        we_d     = 1'b1;
                        addr_d   = wr_addr_i;
                        starve_d = '0;
                    end else begin
                        rd_gnt_o = 1'b1;
                        we_d     = 1'b0;
                        addr_d   = rd_addr_i;
                        if (!wr_req_i) begin
                            starve_d = '0;
                        end else if (starve_q != LIMIT) begin
                            starve_d = starve_q + CW'(1);
                        end
                    end
                end
            end
            S_ISSUE: begin
                cmd_valid_o = 1'b1;
                if (cmd_ready_i) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (cmd_done_i) begin
                    state_d   = S_IDLE;
                    rd_done_o = !we_q;
                    wr_done_o = we_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_we_o   = we_q;
    assign cmd_addr_o = addr_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

    localparam int AW = 24;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          rd_req_i, wr_req_i;
    logic [AW-1:0] rd_addr_i, wr_addr_i;
    logic          rd_gnt_o, rd_done_o, wr_gnt_o, wr_done_o;
    logic          cmd_valid_o, cmd_ready_i, cmd_we_o, cmd_done_i, busy_o;
    logic [AW-1:0] cmd_addr_o;

    int n_cmp  = 0;
    int n_fail = 0;

    sdram_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rd_req_i   (rd_req_i),
        .rd_addr_i  (rd_addr_i),
        .rd_gnt_o   (rd_gnt_o),
        .rd_done_o  (rd_done_o),
        .wr_req_i   (wr_req_i),
        .wr_addr_i  (wr_addr_i),
        .wr_gnt_o   (wr_gnt_o),
        .wr_done_o  (wr_done_o),
        .cmd_valid_o(cmd_valid_o),
        .cmd_ready_i(cmd_ready_i),
        .cmd_we_o   (cmd_we_o),
        .cmd_addr_o (cmd_addr_o),
        .cmd_done_i (cmd_done_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        rd_req_i = 1'b1; wr_req_i = 1'b1;
        rd_addr_i = 24'h0000AA; wr_addr_i = 24'h0000BB;
        cmd_ready_i = 1'b1; cmd_done_i = 1'b1;
        tick(); tick();
        @(negedge clk_i);
        n_cmp++;
        if ({rd_gnt_o, wr_gnt_o, rd_done_o, wr_done_o, cmd_valid_o, cmd_we_o, busy_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {rd_gnt_o, wr_gnt_o, rd_done_o, wr_done_o, cmd_valid_o, cmd_we_o, busy_o});
        end
        n_cmp++;
        if (cmd_addr_o !== 24'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h expected 000000", cmd_addr_o);
        end
        rd_req_i = 1'b0; wr_req_i = 1'b0; cmd_ready_i = 1'b0; cmd_done_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_read_only();
        rd_req_i = 1'b1; rd_addr_i = 24'h000100; cmd_ready_i = 1'b1; cmd_done_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if ({rd_gnt_o, wr_gnt_o} !== 2'b10) begin
            n_fail++; $display("FAIL rd_only_gnt: got %b expected 10", {rd_gnt_o, wr_gnt_o});
        end
        tick();
        rd_req_i = 1'b0; rd_addr_i = 24'hFFFFFF;
        @(negedge clk_i);
        n_cmp++;
        if ({cmd_valid_o, cmd_we_o, busy_o, cmd_addr_o} !== {3'b101, 24'h000100}) begin
            n_fail++;
            $display("FAIL rd_only_cmd: got v=%b we=%b busy=%b addr=%h expected v=1 we=0 busy=1 addr=000100",
                     cmd_valid_o, cmd_we_o, busy_o, cmd_addr_o);
        end
        tick();
        cmd_done_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if ({rd_done_o, wr_done_o, cmd_valid_o} !== 3'b100) begin
            n_fail++; $display("FAIL rd_only_done: got %b expected 100", {rd_done_o, wr_done_o, cmd_valid_o});
        end
        tick();
        cmd_done_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, rd_done_o} !== 2'b00) begin
            n_fail++; $display("FAIL rd_only_idle: got %b expected 00", {busy_o, rd_done_o});
        end
        tick();
    endtask

    task automatic test_starvation();
        // Grant order with both ports held: R R R R W R R R R W R (1 = write)
        logic [10:0] exp_w;
        int ng, last;
        exp_w = 11'b01000010000;
        ng = 0; last = 0;
        rd_req_i = 1'b1; wr_req_i = 1'b1;
        rd_addr_i = 24'h000200; wr_addr_i = 24'h000300;
        cmd_ready_i = 1'b1; cmd_done_i = 1'b1;
        for (int cyc = 0; cyc < 60 && ng < 11; cyc++) begin
            @(negedge clk_i);
            if (rd_gnt_o || wr_gnt_o) begin
                n_cmp++;
                if ({rd_gnt_o, wr_gnt_o} !== (exp_w[ng] ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL starve_order[%0d]: got rd/wr=%b expected %b", ng,
                             {rd_gnt_o, wr_gnt_o}, (exp_w[ng] ? 2'b01 : 2'b10));
                end
                if (ng > 0) begin
                    n_cmp++;
                    if (cyc - last !== 3) begin
                        n_fail++; $display("FAIL starve_spacing[%0d]: got %0d expected 3", ng, cyc - last);
                    end
                end
                last = cyc;
                ng++;
            end
        end
        n_cmp++;
        if (ng !== 11) begin
            n_fail++; $display("FAIL starve_timeout: got %0d grants expected 11", ng);
        end
        tick();
        rd_req_i = 1'b0; wr_req_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (!busy_o) break;
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL starve_drain: got busy=%b expected 0", busy_o);
        end
        tick();
        cmd_done_i = 1'b0;
    endtask

    task automatic test_stall();
        wr_req_i = 1'b1; wr_addr_i = 24'hABCDEF; cmd_ready_i = 1'b0; cmd_done_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if ({wr_gnt_o, rd_gnt_o} !== 2'b10) begin
            n_fail++; $display("FAIL stall_gnt: got wr/rd=%b expected 10", {wr_gnt_o, rd_gnt_o});
        end
        tick();
        wr_req_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_addr_i = 24'h000010 + AW'(i);
            @(negedge clk_i);
            n_cmp++;
            if ({cmd_valid_o, cmd_we_o, cmd_addr_o} !== {2'b11, 24'hABCDEF}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b we=%b addr=%h expected v=1 we=1 addr=abcdef",
                         i, cmd_valid_o, cmd_we_o, cmd_addr_o);
            end
            tick();
        end
        cmd_ready_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (cmd_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL stall_accept_valid: got %b expected 1", cmd_valid_o);
        end
        tick();
        cmd_ready_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if ({cmd_valid_o, busy_o} !== 2'b01) begin
            n_fail++; $display("FAIL stall_wait: got v/busy=%b expected 01", {cmd_valid_o, busy_o});
        end
        tick();
        cmd_done_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if ({wr_done_o, rd_done_o} !== 2'b10) begin
            n_fail++; $display("FAIL stall_done: got wr/rd=%b expected 10", {wr_done_o, rd_done_o});
        end
        tick();
        cmd_done_i = 1'b0;
    endtask

    task automatic test_spurious_done();
        cmd_done_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if ({rd_done_o, wr_done_o, busy_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL spur_idle[%0d]: got %b expected 000", i, {rd_done_o, wr_done_o, busy_o});
            end
            tick();
        end
        rd_req_i = 1'b1; rd_addr_i = 24'h000055; cmd_ready_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (rd_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL spur_gnt: got %b expected 1", rd_gnt_o);
        end
        tick();
        rd_req_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if ({cmd_valid_o, rd_done_o, wr_done_o} !== 3'b100) begin
            n_fail++; $display("FAIL spur_issue: got %b expected 100", {cmd_valid_o, rd_done_o, wr_done_o});
        end
        tick();
        cmd_ready_i = 1'b1; cmd_done_i = 1'b0;
        tick();
        cmd_ready_i = 1'b0; cmd_done_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if ({rd_done_o, wr_done_o} !== 2'b10) begin
            n_fail++; $display("FAIL spur_real_done: got %b expected 10", {rd_done_o, wr_done_o});
        end
        tick();
        cmd_done_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        wr_req_i = 1'b1; wr_addr_i = 24'h123456; cmd_ready_i = 1'b1; cmd_done_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (wr_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_gnt: got %b expected 1", wr_gnt_o);
        end
        tick();
        wr_req_i = 1'b0;
        tick();
        cmd_ready_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, cmd_valid_o, cmd_we_o, cmd_addr_o} !== {3'b101, 24'h123456}) begin
            n_fail++;
            $display("FAIL rstmid_wait: got busy=%b v=%b we=%b addr=%h expected busy=1 v=0 we=1 addr=123456",
                     busy_o, cmd_valid_o, cmd_we_o, cmd_addr_o);
        end
        #1;
        rst_ni = 1'b0; wr_req_i = 1'b1;
        #1;
        n_cmp++;
        if ({rd_gnt_o, wr_gnt_o, rd_done_o, wr_done_o, cmd_valid_o, cmd_we_o, busy_o, cmd_addr_o} !== 31'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got gnt=%b%b done=%b%b v=%b we=%b busy=%b addr=%h expected all 0",
                     rd_gnt_o, wr_gnt_o, rd_done_o, wr_done_o, cmd_valid_o, cmd_we_o, busy_o, cmd_addr_o);
        end
        tick();
        wr_req_i = 1'b0;
        rst_ni = 1'b1;
        tick();
        cmd_done_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if ({rd_done_o, wr_done_o, busy_o} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_nodone: got %b expected 000", {rd_done_o, wr_done_o, busy_o});
        end
        tick();
        cmd_done_i = 1'b0;
    endtask

    task automatic test_random();
        int rd_g, wr_g, rd_d, wr_d, outstanding;
        logic rg_seen, wg_seen, exp_we;
        logic [AW-1:0] exp_addr;
        rd_g = 0; wr_g = 0; rd_d = 0; wr_d = 0; outstanding = 0;
        rg_seen = 1'b0; wg_seen = 1'b0; exp_we = 1'b0; exp_addr = '0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (rg_seen) rd_req_i = 1'b0;
            else if (!rd_req_i && $urandom_range(0, 2) == 0) begin
                rd_req_i = 1'b1; rd_addr_i = AW'($urandom);
            end
            if (wg_seen) wr_req_i = 1'b0;
            else if (!wr_req_i && $urandom_range(0, 2) == 0) begin
                wr_req_i = 1'b1; wr_addr_i = AW'($urandom);
            end
            cmd_ready_i = 1'($urandom_range(0, 1));
            cmd_done_i  = ($urandom_range(0, 3) == 0);
            @(negedge clk_i);
            rg_seen = rd_gnt_o; wg_seen = wr_gnt_o;
            if (rd_gnt_o || wr_gnt_o) begin
                n_cmp++;
                if (outstanding != 0 || (rd_gnt_o && wr_gnt_o)) begin
                    n_fail++;
                    $display("FAIL rand_gnt[%0d]: got outstanding=%0d gnt=%b%b expected outstanding=0 one gnt",
                             i, outstanding, rd_gnt_o, wr_gnt_o);
                end
                outstanding = 1;
                exp_we   = wr_gnt_o;
                exp_addr = wr_gnt_o ? wr_addr_i : rd_addr_i;
                if (rd_gnt_o) rd_g++;
                if (wr_gnt_o) wr_g++;
            end
            if (rd_done_o || wr_done_o) begin
                n_cmp++;
                if (outstanding != 1 || (rd_done_o && wr_done_o) || wr_done_o !== exp_we) begin
                    n_fail++;
                    $display("FAIL rand_done[%0d]: got outstanding=%0d done=%b%b expected outstanding=1 wr_done=%b",
                             i, outstanding, rd_done_o, wr_done_o, exp_we);
                end
                outstanding = 0;
                if (rd_done_o) rd_d++;
                if (wr_done_o) wr_d++;
            end
            if (cmd_valid_o) begin
                n_cmp++;
                if ({cmd_we_o, cmd_addr_o} !== {exp_we, exp_addr}) begin
                    n_fail++;
                    $display("FAIL rand_cmd[%0d]: got we=%b addr=%h expected we=%b addr=%h",
                             i, cmd_we_o, cmd_addr_o, exp_we, exp_addr);
                end
            end
        end
        tick();
        rd_req_i = 1'b0; wr_req_i = 1'b0; cmd_ready_i = 1'b1; cmd_done_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (rd_done_o) rd_d++;
            if (wr_done_o) wr_d++;
        end
        n_cmp++;
        if (rd_g !== rd_d) begin
            n_fail++; $display("FAIL rand_rd_count: got %0d done expected %0d (grants)", rd_d, rd_g);
        end
        n_cmp++;
        if (wr_g !== wr_d) begin
            n_fail++; $display("FAIL rand_wr_count: got %0d done expected %0d (grants)", wr_d, wr_g);
        end
        n_cmp++;
        if (rd_g == 0 || wr_g == 0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_activity: got rd_g=%0d wr_g=%0d busy=%b expected both >0 and busy 0",
                     rd_g, wr_g, busy_o);
        end
        tick();
        cmd_done_i = 1'b0; cmd_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_only();
        test_starvation();
        test_stall();
        test_spurious_done();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, burst start address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive read grants allowed while write waits.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rd_req_i  input  1  display-read burst request, level, held until rd_gnt_o.
REQ-006 SHALL have port rd_addr_i  input  ADDR_WIDTH  read burst address, stable while rd_req_i high.
REQ-007 SHALL have port rd_gnt_o  output  1  one-cycle pulse: read request accepted.
REQ-008 SHALL have port rd_done_o  output  1  one-cycle pulse: read burst completed.
REQ-009 SHALL have port wr_req_i  input  1  fill-write burst request, level, held until wr_gnt_o.
REQ-010 SHALL have port wr_addr_i  input  ADDR_WIDTH  write burst address.
REQ-011 SHALL have port wr_gnt_o  output  1  one-cycle pulse: write request accepted.
REQ-012 SHALL have port wr_done_o  output  1  one-cycle pulse: write burst completed.
REQ-013 SHALL have port cmd_valid_o  output  1  command to SDRAM driver valid.
REQ-014 SHALL have port cmd_ready_i  input  1  driver accepts command when valid and ready.
REQ-015 SHALL have port cmd_we_o  output  1  1 = write burst, 0 = read burst.
REQ-016 SHALL have port cmd_addr_o  output  ADDR_WIDTH  burst address to driver.
REQ-017 SHALL have port cmd_done_i  input  1  one-cycle pulse from driver: current burst finished.
REQ-018 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> WAIT_DONE -> IDLE, with at most one outstanding burst.
REQ-020 IDLE: if any request is pending, SHALL select owner, latch cmd_we_o/cmd_addr_o from the owner's inputs, pulse the owner's gnt for that cycle, and enter ISSUE next cycle.
REQ-021 Selection SHALL prefer read; write SHALL win when starve_cnt == STARVE_LIMIT and wr_req_i is high, or when only wr_req_i is high.
REQ-022 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment on each read grant while wr_req_i is high, saturate at STARVE_LIMIT, and clear on write grant or when wr_req_i is low at a read grant.
REQ-023 ISSUE: cmd_valid_o SHALL be 1; on cmd_valid_o && cmd_ready_i, SHALL enter WAIT_DONE with cmd_valid_o 0 next cycle; cmd_we_o/cmd_addr_o SHALL hold stable until accepted.
REQ-024 WAIT_DONE: on cmd_done_i, SHALL pulse rd_done_o or wr_done_o per the latched owner in the same cycle, and return to IDLE.
REQ-025 cmd_done_i in IDLE or ISSUE SHALL be ignored and produce no done pulse.
REQ-026 A new grant SHALL occur no earlier than the cycle after the return to IDLE, giving a minimum 3-cycle grant-to-grant spacing when cmd_ready_i and cmd_done_i respond immediately.
REQ-027 Request changes after grant SHALL NOT affect the in-flight command.
REQ-028 rd_gnt_o and wr_gnt_o SHALL never be high in the same cycle; likewise rd_done_o and wr_done_o.

Reset
REQ-029 While rst_ni is 0, SHALL force state IDLE, starve_cnt 0, owner read, cmd_valid_o 0, cmd_we_o 0, cmd_addr_o 0, all gnt/done outputs 0, busy_o 0.
REQ-030 Reset asserted mid-burst SHALL abandon the burst with no done pulse; after release, the block SHALL start in IDLE.

Verification
REQ-031 Read only: rd_req_i=1, rd_addr_i=0x000100, ready and done immediate -> rd_gnt_o pulse, cmd_valid_o=1 with cmd_we_o=0 and addr 0x000100, rd_done_o on the done cycle.
REQ-032 Simultaneous requests with reads held continuously -> grant order R,R,R,R,W,R... for STARVE_LIMIT=4; starve_cnt clears after W.
REQ-033 cmd_ready_i held 0 for 10 cycles in ISSUE -> cmd_valid_o stays 1 and cmd_addr_o stays constant; wr_addr_i changes are ignored.
REQ-034 Spurious cmd_done_i in IDLE -> no done pulse and no state change.
REQ-035 rst_ni pulled low in WAIT_DONE -> all outputs 0 immediately and asynchronously; a subsequent cmd_done_i produces no done pulse.
REQ-036 Random stimulus, 10k cycles -> never more than one outstanding burst; done-pulse count equals grant count, checked per requester.
